// File: rtl/module_secuenciador_operandos_pkg.sv
// Shared keypad definitions: key codes, sequencer state encoding and the
// operand-width sanity helper.
package pkg_teclado;

    localparam logic [3:0] TECLA_SIGNO = 4'd10;
    localparam logic [3:0] TECLA_ENTER = 4'd11;
    localparam logic [3:0] TECLA_CLEAR = 4'd13;
    localparam logic [3:0] TECLA_ERR   = 4'd15;

    // The encoding doubles as the display phase code.
    typedef enum logic [2:0] {
        ST_A     = 3'd0,
        ST_B     = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    // True when the largest n_digits decimal number fits in bin_w bits.
    function automatic bit bin_w_ok(input int n_digits, input int bin_w);
        longint p10;
        p10 = 1;
        for (int i = 0; i < n_digits; i++) begin
            p10 = p10 * 10;
        end
        return (p10 - 1) <= ((longint'(1) << bin_w) - 1);
    endfunction

endpackage

// File: rtl/module_secuenciador_operandos_acumulador.sv
// One operand: decimal digit accumulator (acc*10 + d), digit counter and
// sign flop.
module module_acumulador #(
    parameter  int N_DIGITS = 2,
    parameter  int BIN_W    = 7,
    localparam int CNT_W    = $clog2(N_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_digit,
    input  logic             toggle_sign,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] value,
    output logic             sign,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [BIN_W+3:0] acc_ext;
    logic [BIN_W+3:0] acc_next;

    // acc*10 via shifts; the widened sum cannot wrap before truncation.
    assign acc_ext  = {4'b0000, value};
    assign acc_next = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
    assign full     = (count == CNT_W'(N_DIGITS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
            sign  <= 1'b0;
            count <= '0;
        end else if (clr) begin
            value <= '0;
            sign  <= 1'b0;
            count <= '0;
        end else begin
            if (load_digit && !full) begin
                value <= acc_next[BIN_W-1:0];
                count <= count + CNT_W'(1);
            end
            if (toggle_sign) begin
                sign <= ~sign;
            end
        end
    end

endmodule

// File: rtl/module_secuenciador_operandos.sv
// Keypad entry sequencer: collects signed operands A and B, starts the
// multiplier, waits for done and holds the result phase until the next key.
//
// state    | meaning
// ST_A     | entering operand A
// ST_B     | entering operand B
// ST_START | one-cycle start pulse to the multiplier
// ST_WAIT  | waiting for mult_done_i, keys dropped silently
// ST_SHOW  | result on display, any key returns to ST_A
module module_secuenciador_operandos
    import pkg_teclado::*;
#(
    parameter int N_DIGITS = 2,
    parameter int BIN_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid_i,
    input  logic [3:0]       key_code_i,
    input  logic             mult_done_i,
    output logic [BIN_W-1:0] op_a_o,
    output logic [BIN_W-1:0] op_b_o,
    output logic             sign_a_o,
    output logic             sign_b_o,
    output logic             mult_start_o,
    output logic             busy_o,
    output logic [2:0]       fase_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);

    state_t           state;
    state_t           state_next;
    logic             err_next;
    logic             clr_ops;
    logic             load_a, load_b;
    logic             tog_a, tog_b;
    logic [CNT_W-1:0] count_a, count_b;
    logic             full_a, full_b;
    logic             act_b;
    logic             act_full;
    logic             act_empty;
    logic             is_digit;

    module_acumulador #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) u_acc_a (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_ops),
        .load_digit  (load_a),
        .toggle_sign (tog_a),
        .digit       (key_code_i),
        .value       (op_a_o),
        .sign        (sign_a_o),
        .count       (count_a),
        .full        (full_a)
    );

    module_acumulador #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) u_acc_b (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_ops),
        .load_digit  (load_b),
        .toggle_sign (tog_b),
        .digit       (key_code_i),
        .value       (op_b_o),
        .sign        (sign_b_o),
        .count       (count_b),
        .full        (full_b)
    );

    assign act_b     = (state == ST_B);
    assign act_full  = act_b ? full_b : full_a;
    assign act_empty = act_b ? (count_b == '0) : (count_a == '0);
    assign is_digit  = (key_code_i <= 4'd9);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_A;
            err_o <= 1'b0;
        end else begin
            state <= state_next;
            err_o <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        clr_ops    = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        tog_a      = 1'b0;
        tog_b      = 1'b0;
        case (state)
            ST_A, ST_B: begin
                if (key_valid_i) begin
                    if (is_digit) begin
                        if (act_full) begin
                            err_next = 1'b1;
                        end else begin
                            load_a = !act_b;
                            load_b = act_b;
                        end
                    end else begin
                        case (key_code_i)
                            TECLA_SIGNO: begin
                                tog_a = !act_b;
                                tog_b = act_b;
                            end
                            TECLA_ENTER: begin
                                if (act_empty) begin
                                    err_next = 1'b1;
                                end else begin
                                    state_next = act_b ? ST_START : ST_B;
                                end
                            end
                            TECLA_CLEAR: begin
                                clr_ops    = 1'b1;
                                state_next = ST_A;
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mult_done_i) begin
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // The waking key is consumed here, never entered as a digit.
                if (key_valid_i) begin
                    clr_ops    = 1'b1;
                    state_next = ST_A;
                end
            end
            default: state_next = ST_A;
        endcase
    end

    always_comb begin
        mult_start_o = 1'b0;
        busy_o       = 1'b0;
        fase_o       = state;
        case (state)
            ST_START: begin
                mult_start_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_WAIT: busy_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_module_secuenciador_operandos.sv
// Bench for the keypad operand sequencer: a behavioural model predicts each
// cycle, predictions are queued and compared against the DUT after the edge.
module tb_module_secuenciador_operandos;

    localparam int N_DIGITS = 2;
    localparam int BIN_W    = 7;

    logic             clk;
    logic             rst;
    logic             key_valid_i;
    logic [3:0]       key_code_i;
    logic             mult_done_i;
    logic [BIN_W-1:0] op_a_o;
    logic [BIN_W-1:0] op_b_o;
    logic             sign_a_o;
    logic             sign_b_o;
    logic             mult_start_o;
    logic             busy_o;
    logic [2:0]       fase_o;
    logic             err_o;

    module_secuenciador_operandos #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid_i  (key_valid_i),
        .key_code_i   (key_code_i),
        .mult_done_i  (mult_done_i),
        .op_a_o       (op_a_o),
        .op_b_o       (op_b_o),
        .sign_a_o     (sign_a_o),
        .sign_b_o     (sign_b_o),
        .mult_start_o (mult_start_o),
        .busy_o       (busy_o),
        .fase_o       (fase_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fase;
        int a;
        int b;
        int sa;
        int sb;
        int err;
        int start;
        int busy;
    } snap_t;

    snap_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int n_step  = 0;

    // Model state (phase codes 0..4 match the display encoding).
    int m_fase, m_a, m_b, m_sa, m_sb, m_ca, m_cb, m_err;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", tag, n_step, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_a = 0; m_b = 0; m_sa = 0; m_sb = 0; m_ca = 0; m_cb = 0;
    endtask

    task automatic model_step(input bit kv, input int code, input bit done, input bit rv);
        m_err = 0;
        if (!rv) begin
            model_clear();
            m_fase = 0;
        end else begin
            case (m_fase)
                0, 1: if (kv) begin
                    if (code <= 9) begin
                        if (m_fase == 0) begin
                            if (m_ca < N_DIGITS) begin m_a = m_a * 10 + code; m_ca++; end
                            else m_err = 1;
                        end else begin
                            if (m_cb < N_DIGITS) begin m_b = m_b * 10 + code; m_cb++; end
                            else m_err = 1;
                        end
                    end else if (code == 10) begin
                        if (m_fase == 0) m_sa = 1 - m_sa; else m_sb = 1 - m_sb;
                    end else if (code == 11) begin
                        if ((m_fase == 0 ? m_ca : m_cb) == 0) m_err = 1;
                        else m_fase = m_fase + 1;
                    end else if (code == 13) begin
                        model_clear();
                        m_fase = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                2: m_fase = 3;
                3: if (done) m_fase = 4;
                4: if (kv) begin model_clear(); m_fase = 0; end
                default: m_fase = 0;
            endcase
        end
    endtask

    // Drive one cycle of inputs, queue the prediction, compare after the edge.
    task automatic step(input bit kv, input int code, input bit done, input bit rv);
        snap_t s;
        key_valid_i = kv;
        key_code_i  = 4'(code);
        mult_done_i = done;
        rst         = rv;
        model_step(kv, code, done, rv);
        s.fase = m_fase; s.a = m_a; s.b = m_b; s.sa = m_sa; s.sb = m_sb;
        s.err = m_err; s.start = (m_fase == 2); s.busy = (m_fase == 2 || m_fase == 3);
        sb_q.push_back(s);
        @(negedge clk);
        key_valid_i = 1'b0;
        mult_done_i = 1'b0;
        rst         = 1'b1;
        n_step++;
        if (sb_q.size() == 0) begin
            check_val("queue_empty", 0, 1);
        end else begin
            s = sb_q.pop_front();
            check_val("fase",  int'(fase_o),       s.fase);
            check_val("op_a",  int'(op_a_o),       s.a);
            check_val("op_b",  int'(op_b_o),       s.b);
            check_val("sign_a", int'(sign_a_o),    s.sa);
            check_val("sign_b", int'(sign_b_o),    s.sb);
            check_val("err",   int'(err_o),        s.err);
            check_val("start", int'(mult_start_o), s.start);
            check_val("busy",  int'(busy_o),       s.busy);
        end
    endtask

    task automatic key(input int code);
        step(1'b1, code, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p10;
        rst = 1'b0; key_valid_i = 1'b0; key_code_i = 4'd0; mult_done_i = 1'b0;
        m_fase = 0; m_err = 0;
        model_clear();

        p10 = 1;
        for (int i = 0; i < N_DIGITS; i++) p10 = p10 * 10;
        if (p10 - 1 > (1 << BIN_W) - 1) begin
            $display("FAIL param_check got=%0d expected<=%0d", p10 - 1, (1 << BIN_W) - 1);
            $fatal(1, "parameters");
        end

        @(negedge clk);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);

        // 42, enter, -7, enter, start pulse, wait
        key(4); key(2); key(11); key(10); key(7); key(11);
        check_val("start_a", int'(op_a_o), 42);
        check_val("start_b", int'(op_b_o), 7);
        check_val("start_sb", int'(sign_b_o), 1);
        check_val("start_pulse", int'(mult_start_o), 1);
        idle(); idle(); idle();
        check_val("wait_start_low", int'(mult_start_o), 0);
        // key coincident with done is dropped; next key leaves SHOW consumed
        step(1'b1, 3, 1'b1, 1'b1);
        check_val("show_fase", int'(fase_o), 4);
        check_val("show_a_held", int'(op_a_o), 42);
        idle();
        key(5);
        check_val("show_exit_a", int'(op_a_o), 0);

        // digit overflow and empty enter
        key(9); key(9); key(5);
        check_val("ovf_a", int'(op_a_o), 99);
        key(11); key(11);
        check_val("empty_enter_fase", int'(fase_o), 1);
        key(13);

        // clear mid-entry
        key(1); key(2); key(10); key(11); key(3); key(13);
        check_val("clr_fase", int'(fase_o), 0);

        // reset during ST_WAIT, done afterwards ignored
        key(1); key(11); key(2); key(11); idle(); idle();
        step(1'b0, 0, 1'b0, 1'b0);
        check_val("rst_wait_fase", int'(fase_o), 0);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);

        // double sign toggle, invalid codes, signed zero enter
        key(10); key(10); key(8);
        key(12); key(14); key(15);
        check_val("inv_a", int'(op_a_o), 8);
        key(13); key(10); key(11);
        key(10); key(11); key(0); key(11);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
